mem_nzlat_initiator: RTL and testbench
======================================

MEM_NZLAT_INITIATOR -- requirements
Module: mem_nzlat_initiator

Interface
REQ-001 Parameter DATA_WIDTH, default 32: data width in bits, multiple of 8.
REQ-002 Parameter DEPTH, default 1024: memory depth in words.
REQ-003 Parameter TIMEOUT, default 64: maximum WAIT cycles before an error response, at least 2.
REQ-004 Derived constants: ADDR_WIDTH = clog2(DEPTH); OFF_WIDTH = clog2(DATA_WIDTH/8); BADDR_WIDTH = ADDR_WIDTH+OFF_WIDTH.
REQ-005 clk  in  1  clock, rising-edge active.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 req_valid  in  1  upstream request valid.
REQ-008 req_ready  out  1  request accepted on req_valid&&req_ready.
REQ-009 req_we  in  1  1 = write, 0 = read.
REQ-010 req_addr  in  BADDR_WIDTH  byte address.
REQ-011 req_wdata  in  DATA_WIDTH  write data; req_wstrb  in  DATA_WIDTH/8  byte enables.
REQ-012 rsp_valid  out  1  response valid; rsp_ready  in  1  response consumed on rsp_valid&&rsp_ready.
REQ-013 rsp_rdata  out  DATA_WIDTH  read data (0 for writes and errors); rsp_err  out  1  misaligned or timeout; rsp_we  out  1  echo of req_we.
REQ-014 mem_addr  out  ADDR_WIDTH, mem_wdata  out  DATA_WIDTH, mem_wstrb  out  DATA_WIDTH/8, mem_write  out  1, mem_read  out  1: memory-side command.
REQ-015 mem_rdata  in  DATA_WIDTH, mem_ready  in  1: memory-side completion; mem_rdata valid only in the mem_ready cycle.
REQ-016 err_count  out  16  saturating count of error responses.

Function
REQ-017 FSM states IDLE, ISSUE, WAIT, RESP; all outputs are registered or decoded from state only, with no combinational input-to-output path.
REQ-018 req_ready is 1 only in IDLE with drain_pending=0.
REQ-019 On acceptance, the block latches we/addr/wdata/wstrb; if addr[OFF_WIDTH-1:0]!=0, it goes to RESP with rsp_err=1 and issues no memory command; otherwise it goes to ISSUE.
REQ-020 ISSUE, exactly one cycle: mem_write=1 if we, else mem_read=1 (never both); mem_addr=addr[BADDR_WIDTH-1:OFF_WIDTH]; wdata/wstrb driven; then WAIT.
REQ-021 Outside ISSUE: mem_write=mem_read=0; mem_addr/mem_wdata/mem_wstrb=0.
REQ-022 WAIT: wait_cnt starts at 0 and increments each cycle; on mem_ready, capture mem_rdata (reads only, else 0), set rsp_err=0, and go to RESP.
REQ-023 WAIT with no mem_ready when wait_cnt==TIMEOUT-1: go to RESP with rsp_err=1, rsp_rdata=0, set drain_pending=1.
REQ-024 mem_ready in the same cycle as the timeout condition counts as success.
REQ-025 RESP: rsp_valid=1, payload stable until rsp_ready; on handshake go to IDLE; rsp_valid is never asserted outside RESP.
REQ-026 Latency: mem_ready in cycle N gives rsp_valid in cycle N+1; acceptance in cycle 0 gives the mem command in cycle 1.
REQ-027 drain_pending clears on the first mem_ready seen outside WAIT; mem_ready outside WAIT never affects the response path.
REQ-028 err_count increments by 1 per error response at RESP entry, saturating at 0xFFFF.
REQ-029 Writes with req_wstrb=0 are still issued as memory commands.

Reset
REQ-030 rst_n low asynchronously forces IDLE, drain_pending=0, wait_cnt=0, err_count=0, and all outputs 0 (req_ready goes to 1 after release).
REQ-031 Reset mid-transaction drops the transaction silently, with no response after release.

Structure
REQ-032 Shared package mem_nzlat_pkg holds the state enum (IDLE/ISSUE/WAIT/RESP) and the default width/TIMEOUT constants.
REQ-033 No sub-module; the timeout counter is inline, width clog2(TIMEOUT+1).

Verification
REQ-034 Read at byte addr 0x010 of a word preloaded with 0xDEADBEEF, memory latency 3 -> mem_read for 1 cycle with mem_addr=0x004; rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid one cycle after mem_ready.
REQ-035 Write 0xA5A5A5A5 with wstrb=0b0101 at addr 0x020 over 0x11223344, then read back -> read returns 0x11A533A5; mem_write pulses exactly once.
REQ-036 Read at addr 0x003 -> rsp_err=1, rsp_rdata=0, no mem_read/mem_write, err_count=1.
REQ-037 Stub memory withholds mem_ready for TIMEOUT=8 -> rsp_err=1 after 8 WAIT cycles; req_ready=0 until a late mem_ready is seen, then 1.
REQ-038 rsp_ready held 0 for 10 cycles -> rsp_valid and payload stable throughout; no new acceptance until the handshake.
REQ-039 rst_n asserted during WAIT -> all outputs 0 immediately; a later mem_ready produces no response; next request completes normally.

Source files
------------

// File: rtl/mem_nzlat_pkg.sv
// Shared definitions for the non-zero-latency memory initiator.
//   state_t           : FSM state encoding (IDLE / ISSUE / WAIT / RESP)
//   DEF_DATA_WIDTH    : default data width in bits
//   DEF_DEPTH         : default memory depth in words
//   DEF_TIMEOUT       : default maximum WAIT cycles before an error response
package mem_nzlat_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_DEPTH      = 1024;
    localparam int DEF_TIMEOUT    = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/mem_nzlat_initiator.sv
// Single-outstanding memory initiator: accepts one byte-addressed request,
// issues a one-cycle command to a variable-latency memory, waits (bounded by
// TIMEOUT) for completion and returns one response.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are
// both 1. The producer holds valid and its payload stable until that edge; the
// consumer may raise or lower ready freely. Here req_ready and rsp_valid are
// registered, so neither depends combinationally on any input.
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   req_valid/req_ready         upstream request handshake
//   req_we/req_addr/req_wdata/req_wstrb  request payload (byte address)
//   rsp_valid/rsp_ready         response handshake
//   rsp_rdata/rsp_err/rsp_we    response payload
//   mem_addr/mem_wdata/mem_wstrb/mem_write/mem_read  memory command (ISSUE only)
//   mem_rdata/mem_ready         memory completion (rdata valid with mem_ready)
//   err_count                   saturating count of error responses
//   fsm_state                   current FSM state (debug visibility)
module mem_nzlat_initiator
    import mem_nzlat_pkg::*;
#(
    parameter  int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter  int DEPTH       = DEF_DEPTH,
    parameter  int TIMEOUT     = DEF_TIMEOUT,
    localparam int ADDR_WIDTH  = $clog2(DEPTH),
    localparam int OFF_WIDTH   = $clog2(DATA_WIDTH / 8),
    localparam int BADDR_WIDTH = ADDR_WIDTH + OFF_WIDTH,
    localparam int STRB_WIDTH  = DATA_WIDTH / 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [BADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]  req_wdata,
    input  logic [STRB_WIDTH-1:0]  req_wstrb,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_WIDTH-1:0]  rsp_rdata,
    output logic                   rsp_err,
    output logic                   rsp_we,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0]  mem_wdata,
    output logic [STRB_WIDTH-1:0]  mem_wstrb,
    output logic                   mem_write,
    output logic                   mem_read,
    input  logic [DATA_WIDTH-1:0]  mem_rdata,
    input  logic                   mem_ready,
    output logic [15:0]            err_count,
    output state_t                 fsm_state
);

    localparam int CNT_WIDTH = $clog2(TIMEOUT + 1);

    logic                 lat_we;
    logic [CNT_WIDTH-1:0] wait_cnt;
    logic                 drain_pending;
    logic                 misaligned;
    logic                 drain_clr;

    // Modulo by the bytes-per-word keeps this valid even for 8-bit data.
    assign misaligned = (req_addr % BADDR_WIDTH'(STRB_WIDTH)) != '0;

    // A timed-out command may still complete later; that late mem_ready is
    // absorbed here and must never reach the response path.
    assign drain_clr = mem_ready && (fsm_state != WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_state     <= IDLE;
            req_ready     <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_err       <= 1'b0;
            rsp_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_wstrb     <= '0;
            mem_write     <= 1'b0;
            mem_read      <= 1'b0;
            err_count     <= '0;
            lat_we        <= 1'b0;
            wait_cnt      <= '0;
            drain_pending <= 1'b0;
        end else begin
            // Memory command is a single-cycle pulse: cleared every cycle
            // unless the transition into ISSUE sets it below.
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            mem_write <= 1'b0;
            mem_read  <= 1'b0;

            if (drain_clr) begin
                drain_pending <= 1'b0;
            end

            case (fsm_state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        lat_we    <= req_we;
                        req_ready <= 1'b0;
                        if (misaligned) begin
                            fsm_state <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                            rsp_we    <= req_we;
                            if (err_count != 16'hFFFF) begin
                                err_count <= err_count + 16'd1;
                            end
                        end else begin
                            fsm_state <= ISSUE;
                            mem_write <= req_we;
                            mem_read  <= !req_we;
                            mem_addr  <= ADDR_WIDTH'(req_addr >> OFF_WIDTH);
                            mem_wdata <= req_wdata;
                            mem_wstrb <= req_wstrb;
                        end
                    end else begin
                        req_ready <= !drain_pending || drain_clr;
                    end
                end

                ISSUE: begin
                    fsm_state <= WAIT;
                    wait_cnt  <= '0;
                end

                WAIT: begin
                    // Completion wins over a timeout landing in the same cycle.
                    if (mem_ready) begin
                        fsm_state <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= lat_we ? '0 : mem_rdata;
                        rsp_we    <= lat_we;
                    end else if (wait_cnt == CNT_WIDTH'(TIMEOUT - 1)) begin
                        fsm_state     <= RESP;
                        rsp_valid     <= 1'b1;
                        rsp_err       <= 1'b1;
                        rsp_rdata     <= '0;
                        rsp_we        <= lat_we;
                        drain_pending <= 1'b1;
                        if (err_count != 16'hFFFF) begin
                            err_count <= err_count + 16'd1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + CNT_WIDTH'(1);
                    end
                end

                RESP: begin
                    if (rsp_ready) begin
                        fsm_state <= IDLE;
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_we    <= 1'b0;
                        req_ready <= !drain_pending || drain_clr;
                    end
                end

                default: fsm_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_nzlat_initiator.sv
// Directed bench for mem_nzlat_initiator with a behavioural latency memory.
module tb_mem_nzlat_initiator;
    import mem_nzlat_pkg::*;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int BW = 12;
    localparam int SW = 4;
    localparam int RW = DW + 2;   // {we, err, rdata}

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready, req_we;
    logic [BW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [SW-1:0] req_wstrb;
    logic          rsp_valid, rsp_ready, rsp_err, rsp_we;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [SW-1:0] mem_wstrb;
    logic          mem_write, mem_read, mem_ready;
    logic [15:0]   err_count;
    state_t        fsm_state;

    mem_nzlat_initiator #(.DATA_WIDTH(DW), .DEPTH(1024), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_we(rsp_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_write(mem_write), .mem_read(mem_read),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .err_count(err_count), .fsm_state(fsm_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------- bookkeeping ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [RW-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- memory stub ----------------
    logic [DW-1:0] mem_arr [0:1023];
    int            mem_lat   = 3;
    bit            withhold  = 1'b0;
    bit            kick      = 1'b0;
    int            pend_cnt  = 0;
    logic [AW-1:0] pend_addr = '0;
    logic [AW-1:0] last_addr = '0;
    int            n_rd = 0, n_wr = 0, n_both = 0, n_idle_bad = 0;
    int            cmd_cyc = 0, ready_cyc = 0;

    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            mem_rdata = '0;
            if (mem_read && mem_write) n_both++;
            if (!mem_read && !mem_write && (mem_addr != '0 || mem_wdata != '0 || mem_wstrb != '0))
                n_idle_bad++;
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    // Returns stored data for writes too; the DUT must zero it.
                    mem_ready = 1'b1;
                    mem_rdata = mem_arr[pend_addr];
                    ready_cyc = cyc;
                end
            end else if (kick) begin
                kick      = 1'b0;
                mem_ready = 1'b1;
                mem_rdata = 32'hBAD0BAD0;
                ready_cyc = cyc;
            end
            if (mem_read || mem_write) begin
                cmd_cyc   = cyc;
                last_addr = mem_addr;
                if (mem_read) n_rd++;
                if (mem_write) begin
                    n_wr++;
                    for (int b = 0; b < SW; b++)
                        if (mem_wstrb[b]) mem_arr[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
                end
                pend_addr = mem_addr;
                pend_cnt  = withhold ? 0 : mem_lat;
            end
        end
    end

    // ---------------- response monitor / scoreboard ----------------
    int            n_rsp    = 0;
    int            rise_cyc = 0;
    logic          prev_valid = 1'b0;
    logic [RW-1:0] exp_v;

    initial forever begin
        @(negedge clk);
        if (rsp_valid && !prev_valid) rise_cyc = cyc;
        if (rsp_valid && rsp_ready) begin
            n_rsp++;
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 64'(n_rsp), 64'(n_rsp - 1));
            end else begin
                exp_v = exp_q.pop_front();
                check("rsp_payload", 64'({rsp_we, rsp_err, rsp_rdata}), 64'(exp_v));
            end
        end
        prev_valid = rsp_valid;
    end

    // ---------------- driver tasks ----------------
    int acc_cyc = 0;

    task automatic send_req(input logic we, input logic [BW-1:0] addr, input logic [DW-1:0] wdata,
                            input logic [SW-1:0] wstrb, input logic [RW-1:0] exp);
        bit done = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (req_ready) begin
                acc_cyc = cyc;
                exp_q.push_back(exp);
                done = 1'b1;
            end
        end
        if (!done) check("accept_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    endtask

    task automatic wait_rsp_done(input string name);
        int k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() != 0) begin
            check(name, 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
    endtask

    // ---------------- main sequence ----------------
    int            rd0, wr0, snap, bad_stable, bad_ready, k;
    logic [RW-1:0] cap;

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; req_wstrb = '0; rsp_ready = 1'b1;
        for (int i = 0; i < 1024; i++) mem_arr[i] = '0;
        mem_arr[4] = 32'hDEADBEEF;
        mem_arr[8] = 32'h11223344;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_err_count", 64'(err_count), 64'd0);
        check("rst_state", 64'(fsm_state), 64'(IDLE));
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        check("post_rst_req_ready", 64'(req_ready), 64'd1);

        // Aligned read, latency 3
        mem_lat = 3; rd0 = n_rd;
        send_req(1'b0, 12'h010, '0, '0, {1'b0, 1'b0, 32'hDEADBEEF});
        wait_rsp_done("rd_deadbeef_timeout");
        check("rd_cmd_latency", 64'(cmd_cyc), 64'(acc_cyc + 1));
        check("rd_mem_addr", 64'(last_addr), 64'h004);
        check("rd_pulse_count", 64'(n_rd - rd0), 64'd1);
        check("rd_rsp_latency", 64'(rise_cyc), 64'(ready_cyc + 1));

        // Partial write then read back
        wr0 = n_wr;
        send_req(1'b1, 12'h020, 32'hA5A5A5A5, 4'b0101, {1'b1, 1'b0, 32'h0});
        wait_rsp_done("wr_timeout");
        check("wr_pulse_count", 64'(n_wr - wr0), 64'd1);
        check("wr_mem_addr", 64'(last_addr), 64'h008);
        send_req(1'b0, 12'h020, '0, '0, {1'b0, 1'b0, 32'h11A533A5});
        wait_rsp_done("rdback_timeout");

        // Zero-strobe write is still issued
        wr0 = n_wr;
        send_req(1'b1, 12'h020, 32'hFFFFFFFF, 4'b0000, {1'b1, 1'b0, 32'h0});
        wait_rsp_done("wr0_timeout");
        check("wr0_pulse_count", 64'(n_wr - wr0), 64'd1);

        // Misaligned read: immediate error, no memory command
        rd0 = n_rd; wr0 = n_wr;
        send_req(1'b0, 12'h003, '0, '0, {1'b0, 1'b1, 32'h0});
        wait_rsp_done("misal_timeout");
        check("misal_no_cmd", 64'((n_rd - rd0) + (n_wr - wr0)), 64'd0);
        check("misal_err_count", 64'(err_count), 64'd1);
        check("misal_rsp_latency", 64'(rise_cyc), 64'(acc_cyc + 1));

        // Timeout: ISSUE cycle + 8 WAIT cycles, response on the next cycle
        withhold = 1'b1;
        send_req(1'b0, 12'h010, '0, '0, {1'b0, 1'b1, 32'h0});
        wait_rsp_done("to_timeout");
        check("to_rsp_latency", 64'(rise_cyc), 64'(cmd_cyc + 9));
        check("to_err_count", 64'(err_count), 64'd2);
        bad_ready = 0;
        repeat (4) begin
            @(negedge clk);
            if (req_ready) bad_ready++;
        end
        check("drain_blocks_ready", 64'(bad_ready), 64'd0);
        withhold = 1'b0;
        @(posedge clk); #1 kick = 1'b1;
        @(negedge clk);              // stub raises late mem_ready here
        @(negedge clk);
        check("drain_release_ready", 64'(req_ready), 64'd1);

        // mem_ready in the same cycle as the timeout wins
        mem_lat = 8;
        send_req(1'b0, 12'h010, '0, '0, {1'b0, 1'b0, 32'hDEADBEEF});
        wait_rsp_done("edge_timeout");
        check("edge_err_count", 64'(err_count), 64'd2);

        // Response backpressure for 10 cycles
        mem_lat = 2;
        @(posedge clk); #1 rsp_ready = 1'b0;
        send_req(1'b0, 12'h010, '0, '0, {1'b0, 1'b0, 32'hDEADBEEF});
        k = 0;
        while (!rsp_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("bp_valid_seen", 64'(rsp_valid), 64'd1);
        cap = {rsp_we, rsp_err, rsp_rdata};
        bad_stable = 0; bad_ready = 0;
        repeat (10) begin
            @(negedge clk);
            if (!rsp_valid || {rsp_we, rsp_err, rsp_rdata} != cap) bad_stable++;
            if (req_ready) bad_ready++;
        end
        check("bp_stable", 64'(bad_stable), 64'd0);
        check("bp_no_accept", 64'(bad_ready), 64'd0);
        @(posedge clk); #1 rsp_ready = 1'b1;
        wait_rsp_done("bp_timeout");

        // Reset while in WAIT drops the transaction
        mem_lat = 5;
        send_req(1'b0, 12'h010, '0, '0, {1'b0, 1'b0, 32'hDEADBEEF});
        @(posedge clk); @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_state", 64'(fsm_state), 64'(IDLE));
        check("midrst_outputs", 64'({rsp_valid, req_ready, mem_read, mem_write, rsp_err}), 64'd0);
        check("midrst_err_count", 64'(err_count), 64'd0);
        exp_q.delete();
        snap = n_rsp;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("midrst_no_rsp", 64'(n_rsp), 64'(snap));
        check("midrst_ready", 64'(req_ready), 64'd1);

        // Normal transaction after reset
        mem_lat = 1;
        send_req(1'b0, 12'h020, '0, '0, {1'b0, 1'b0, 32'h11A533A5});
        wait_rsp_done("final_timeout");
        check("final_err_count", 64'(err_count), 64'd0);

        repeat (3) @(negedge clk);
        check("no_both_cmds", 64'(n_both), 64'd0);
        check("idle_cmd_zero", 64'(n_idle_bad), 64'd0);
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
